alu_op_sequencer: RTL

- Sequences the 2-bit combinational ALU/comparator/multiplier datapath on behalf of a microcontroller-side requester.
- Accepts one macro-operation per valid/ready handshake and steps the ALU select code through the required sub-steps (the 2-bit add/sub needs three). After each settle window it captures the active ALU outputs and returns one packed 4-bit result on a valid/ready response channel.
- Sits between the MC interface logic and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 73 +++++++
 rtl/alu_seq_step_rom.sv | 64 ++++++
 rtl/alu_op_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op/select encodings, FSM states and capture kinds
// for the ALU op sequencer.
package alu_seq_pkg;

  // Macro-operation encodings carried on req_op (5..7 are illegal)
  localparam logic [2:0] OP_CMP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_LOGIC = 3'd4;

  // ALU select codes
  localparam logic [3:0] SEL_CMP    = 4'd0;
  localparam logic [3:0] SEL_NOR    = 4'd1;
  localparam logic [3:0] SEL_DIV    = 4'd2;
  localparam logic [3:0] SEL_OR     = 4'd3;
  localparam logic [3:0] SEL_MUL    = 4'd4;
  localparam logic [3:0] SEL_NAND   = 4'd5;
  localparam logic [3:0] SEL_SUM1   = 4'd6;
  localparam logic [3:0] SEL_AND    = 4'd7;
  localparam logic [3:0] SEL_CARRY0 = 4'd8;
  localparam logic [3:0] SEL_NOT4   = 4'd9;
  localparam logic [3:0] SEL_SUM0   = 4'd10;
  localparam logic [3:0] SEL_NOT3   = 4'd11;
  localparam logic [3:0] SEL_XNOR   = 4'd12;
  localparam logic [3:0] SEL_NOT2   = 4'd13;
  localparam logic [3:0] SEL_XOR    = 4'd14;
  localparam logic [3:0] SEL_NOT1   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_RESP
  } state_e;

  // Which ALU output bits are captured at the end of a step
  typedef enum logic [2:0] {
    CAP_NONE,
    CAP_CMP,
    CAP_SUM0,
    CAP_SUM1C1,
    CAP_MUL,
    CAP_DIV,
    CAP_LGC
  } cap_e;

  // True when fn selects one of the ten logic functions
  function automatic logic fnLegal(input logic [3:0] fn);
    case (fn)
      SEL_AND, SEL_NAND, SEL_OR, SEL_NOR, SEL_NOT1,
      SEL_NOT2, SEL_NOT3, SEL_NOT4, SEL_XOR, SEL_XNOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Bit position of a logic function inside the alu_lgc bus
  function automatic logic [3:0] lgcIndex(input logic [3:0] fn);
    case (fn)
      SEL_AND:  return 4'd0;
      SEL_NAND: return 4'd1;
      SEL_OR:   return 4'd2;
      SEL_NOR:  return 4'd3;
      SEL_NOT1: return 4'd4;
      SEL_NOT2: return 4'd5;
      SEL_NOT3: return 4'd6;
      SEL_NOT4: return 4'd7;
      SEL_XOR:  return 4'd8;
      SEL_XNOR: return 4'd9;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_step_rom.sv
// alu_seq_step_rom: maps (op, fn, step index) to the ALU select code,
// the capture kind for that step, a last-step flag and an illegal flag.
module alu_seq_step_rom
  import alu_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [3:0] i_fn,
  input  logic [1:0] i_step,
  output logic [3:0] o_sel,
  output cap_e       o_cap,
  output logic       o_last,
  output logic       o_illegal
);

  // Step table lookup; ADD is the only three-step operation
  always_comb begin
    o_sel     = SEL_CMP;
    o_cap     = CAP_NONE;
    o_last    = 1'b1;
    o_illegal = 1'b0;
    case (i_op)
      OP_CMP: begin
        o_sel = SEL_CMP;
        o_cap = CAP_CMP;
      end
      OP_ADD: begin
        case (i_step)
          2'd0: begin
            o_sel  = SEL_SUM0;
            o_cap  = CAP_SUM0;
            o_last = 1'b0;
          end
          2'd1: begin
            o_sel  = SEL_CARRY0;
            o_cap  = CAP_NONE;
            o_last = 1'b0;
          end
          default: begin
            o_sel = SEL_SUM1;
            o_cap = CAP_SUM1C1;
          end
        endcase
      end
      OP_MUL: begin
        o_sel = SEL_MUL;
        o_cap = CAP_MUL;
      end
      OP_DIV: begin
        o_sel = SEL_DIV;
        o_cap = CAP_DIV;
      end
      OP_LOGIC: begin
        if (fnLegal(i_fn)) begin
          o_sel = i_fn;
          o_cap = CAP_LGC;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one macro-op per request handshake, steps the
// 2-bit ALU select through the op's sub-steps, and returns a packed 4-bit
// result on a valid/ready response channel.
// Optional handshake statistics counters: define ALU_SEQ_STATS_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [3:0]  i_req_fn,
  input  logic        i_req_sub,
  input  logic [1:0]  i_req_a,
  input  logic [1:0]  i_req_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [3:0]  o_rsp_data,
  output logic        o_rsp_err,
  output logic [1:0]  o_alu_a,
  output logic [1:0]  o_alu_b,
  output logic [3:0]  o_alu_sel,
  output logic        o_alu_key,
  input  logic [9:0]  i_alu_lgc,
  input  logic [2:0]  i_alu_cmp,
  input  logic [1:0]  i_alu_s,
  input  logic [1:0]  i_alu_c,
  input  logic [3:0]  i_alu_m,
`ifdef ALU_SEQ_STATS_EN
  input  logic [1:0]  i_alu_d,
  output logic [15:0] o_stat_ops,
  output logic [7:0]  o_stat_errs
`else
  input  logic [1:0]  i_alu_d
`endif
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC);

  state_e     r_state;
  state_e     w_nextState;
  logic [2:0] r_op;
  logic [3:0] r_fn;
  logic       r_sub;
  logic [1:0] r_a;
  logic [1:0] r_b;
  logic [1:0] r_step;
  logic [2:0] r_settle;
  logic [3:0] r_result;
  logic       r_err;

  logic       w_accept;
  logic       w_stepDone;
  logic [2:0] w_romOp;
  logic [3:0] w_romFn;
  logic [1:0] w_romStep;
  logic [3:0] w_romSel;
  cap_e       w_romCap;
  logic       w_romLast;
  logic       w_romIllegal;
  logic [3:0] w_captured;
  logic       w_unused;

  // carry bit 0 is internal to the ALU add chain and never reported
  assign w_unused = i_alu_c[0];

  // In IDLE the ROM screens the incoming request; otherwise it walks the held op
  assign w_romOp   = (r_state == ST_IDLE) ? i_req_op : r_op;
  assign w_romFn   = (r_state == ST_IDLE) ? i_req_fn : r_fn;
  assign w_romStep = (r_state == ST_IDLE) ? 2'd0 : r_step;

  alu_seq_step_rom u_rom (
    .i_op      (w_romOp),
    .i_fn      (w_romFn),
    .i_step    (w_romStep),
    .o_sel     (w_romSel),
    .o_cap     (w_romCap),
    .o_last    (w_romLast),
    .o_illegal (w_romIllegal)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state and handshake/ALU drive; ALU pins sit at zero outside STEP
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_stepDone  = 1'b0;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_alu_a     = 2'd0;
    o_alu_b     = 2'd0;
    o_alu_sel   = 4'd0;
    o_alu_key   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept    = 1'b1;
          w_nextState = w_romIllegal ? ST_RESP : ST_STEP;
        end
      end
      ST_STEP: begin
        o_alu_a    = r_a;
        o_alu_b    = r_b;
        o_alu_key  = (r_op == OP_ADD) && r_sub;
        o_alu_sel  = w_romSel;
        w_stepDone = (r_settle == SETTLE_LAST);
        if (w_stepDone && w_romLast) w_nextState = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Merge only the ALU bits owned by the current step into the result
  always_comb begin
    w_captured = r_result;
    case (w_romCap)
      CAP_CMP:    w_captured = {1'b0, i_alu_cmp};
      CAP_SUM0:   w_captured = {r_result[3:1], i_alu_s[0]};
      CAP_SUM1C1: w_captured = {1'b0, i_alu_c[1], i_alu_s[1], r_result[0]};
      CAP_MUL:    w_captured = i_alu_m;
      CAP_DIV:    w_captured = {2'b00, i_alu_d};
      CAP_LGC:    w_captured = {3'b000, i_alu_lgc[lgcIndex(r_fn)]};
      default:    w_captured = r_result;
    endcase
  end

  // Operand capture, settle/step counting and result accumulation
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op     <= 3'd0;
      r_fn     <= 4'd0;
      r_sub    <= 1'b0;
      r_a      <= 2'd0;
      r_b      <= 2'd0;
      r_step   <= 2'd0;
      r_settle <= 3'd0;
      r_result <= 4'd0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_op     <= i_req_op;
      r_fn     <= i_req_fn;
      r_sub    <= i_req_sub;
      r_a      <= i_req_a;
      r_b      <= i_req_b;
      r_step   <= 2'd0;
      r_settle <= 3'd0;
      r_result <= 4'd0;
      r_err    <= w_romIllegal;
    end else if (r_state == ST_STEP) begin
      if (w_stepDone) begin
        r_settle <= 3'd0;
        r_step   <= r_step + 2'd1;
        r_result <= w_captured;
      end else begin
        r_settle <= r_settle + 3'd1;
      end
    end
  end

  assign o_rsp_data = r_result;
  assign o_rsp_err  = r_err;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] r_statOps;
  logic [7:0]  r_statErrs;

  // Saturating counts of completed responses and of error responses
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_statOps  <= 16'd0;
      r_statErrs <= 8'd0;
    end else if (o_rsp_valid && i_rsp_ready) begin
      if (r_statOps != 16'hFFFF) r_statOps <= r_statOps + 16'd1;
      if (r_err && (r_statErrs != 8'hFF)) r_statErrs <= r_statErrs + 8'd1;
    end
  end

  assign o_stat_ops  = r_statOps;
  assign o_stat_errs = r_statErrs;
`endif

endmodule
